// File: rtl/alarme_siren_ctrl.sv
// Alarm siren back end: qualifies alarm_in, latches an alarm, blinks the
// siren, steady lamp, ack/silence with re-sound, holdoff, saturating count.
// Ports:
//   clk, rst (sync, active high), alarm_in, arm, ack  -- inputs
//   siren, lamp (registered), state_o[2:0], event_count[CNT_W-1:0]
module alarme_siren_ctrl #(
  parameter int QUAL_CYCLES    = 4,
  parameter int BLINK_HALF     = 8,
  parameter int SILENCE_CYCLES = 32,
  parameter int HOLDOFF_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alarm_in,
  input  logic             arm,
  input  logic             ack,
  output logic             siren,
  output logic             lamp,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] event_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_QUAL  = 3'd1,
    S_ALARM = 3'd2,
    S_SIL   = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] QUAL_LAST  = CNT_W'(QUAL_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_HALF - 1);
  localparam logic [CNT_W-1:0] SIL_LAST   = CNT_W'(SILENCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] blink_q, blink_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             siren_q, siren_d;
  logic             lamp_q, lamp_d;
  // new_event: counted alarm entry; blink_start: restart blink phase
  logic             new_event;
  logic             blink_start;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      blink_q <= '0;
      count_q <= '0;
      siren_q <= 1'b0;
      lamp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      blink_q <= blink_d;
      count_q <= count_d;
      siren_q <= siren_d;
      lamp_q  <= lamp_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    new_event   = 1'b0;
    blink_start = 1'b0;
    if (!arm) begin
      state_d = S_IDLE;
      timer_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (alarm_in) begin
            if (QUAL_CYCLES == 1) begin
              state_d     = S_ALARM;
              timer_d     = '0;
              new_event   = 1'b1;
              blink_start = 1'b1;
            end else begin
              state_d = S_QUAL;
              timer_d = ONE;
            end
          end
        end
        S_QUAL: begin
          if (!alarm_in) begin
            state_d = S_IDLE;
            timer_d = '0;
          end else if (timer_q == QUAL_LAST) begin
            state_d     = S_ALARM;
            timer_d     = '0;
            new_event   = 1'b1;
            blink_start = 1'b1;
          end else begin
            timer_d = timer_q + ONE;
          end
        end
        S_ALARM: begin
          if (ack) begin
            state_d = S_SIL;
            timer_d = '0;
          end
        end
        S_SIL: begin
          if (ack) begin
            timer_d = '0;
          end else if (timer_q == SIL_LAST) begin
            timer_d = '0;
            if (alarm_in) begin
              // re-sound: blink restarts, not a new event
              state_d     = S_ALARM;
              blink_start = 1'b1;
            end else begin
              state_d = S_HOLD;
            end
          end else begin
            timer_d = timer_q + ONE;
          end
        end
        S_HOLD: begin
          if (timer_q == HOLD_LAST) begin
            state_d = S_IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + ONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    lamp_d  = (state_d == S_ALARM) || (state_d == S_SIL);
    count_d = count_q;
    if (new_event && (count_q != CNT_MAX))
      count_d = count_q + ONE;
    siren_d = 1'b0;
    blink_d = '0;
    if (state_d == S_ALARM) begin
      if (blink_start) begin
        siren_d = 1'b1;
      end else if (blink_q == BLINK_LAST) begin
        siren_d = !siren_q;
      end else begin
        blink_d = blink_q + ONE;
        siren_d = siren_q;
      end
    end
  end

  assign siren       = siren_q;
  assign lamp        = lamp_q;
  assign state_o     = state_q;
  assign event_count = count_q;

endmodule

// File: doc/alarme_siren_ctrl.md
Name: alarme_siren_ctrl

Overview:
- Sequential back end for the combinational alarm decoder.
- Consumes the decoder's single-bit alarm output (`alarm_in`) and qualifies it against glitches.
- Latches a qualified alarm and drives a blinking siren plus a steady lamp.
- Supports operator acknowledge/silence with automatic re-sound, a post-alarm holdoff, and a saturating event counter.

Parameters:
- QUAL_CYCLES, 4, consecutive high samples of `alarm_in` needed to declare an alarm (legal range ≥1).
- BLINK_HALF, 8, cycles per siren half-period in ALARM (legal range ≥1).
- SILENCE_CYCLES, 32, length of the SILENCED interval in cycles (legal range ≥1).
- HOLDOFF_CYCLES, 16, length of the HOLDOFF interval in cycles (legal range ≥1).
- CNT_W, 8, width of the internal timer and of `event_count`.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- alarm_in  input  1  alarm request from the combinational alarm decoder output.
- arm  input  1  level; 1 = system armed, 0 = forced idle.
- ack  input  1  operator acknowledge, sampled each cycle.
- siren  output  1  siren drive (blinking), registered.
- lamp  output  1  alarm lamp, registered.
- state_o  output  3  current state: IDLE=0, QUALIFY=1, ALARM=2, SILENCED=3, HOLDOFF=4.
- event_count  output  CNT_W  number of qualified alarms, saturating.

Behaviour:
- Reset and priority:
  - rst=1 at an edge puts state=IDLE, clears all timers, and sets siren=0, lamp=0, event_count=0.
  - rst has priority over everything, including mid-alarm.
  - arm=0 at an edge (rst=0) forces IDLE from any state and clears timers and outputs. event_count is retained.
- All outputs are registered and change only on clock edges.
- IDLE:
  - siren=0, lamp=0.
  - If arm=1 and alarm_in=1: if QUAL_CYCLES=1 go to ALARM, else go to QUALIFY with qual count=1.
- QUALIFY:
  - siren=0, lamp=0.
  - alarm_in=0 → IDLE.
  - alarm_in=1 with count=QUAL_CYCLES-1 → ALARM; otherwise count+1.
  - Net result: ALARM is entered on the edge that samples the QUAL_CYCLES-th consecutive high.
- ALARM entry (from QUALIFY or IDLE only):
  - event_count += 1, saturating at 2^CNT_W-1.
  - Blink phase reset; siren=1 and lamp=1 from the entry edge.
- ALARM:
  - lamp=1; siren alternates BLINK_HALF cycles high, then BLINK_HALF cycles low, and so on.
  - The alarm is latched: alarm_in going low has no effect.
  - ack=1 → SILENCED. ack beats a coincident blink toggle.
- SILENCED:
  - siren=0, lamp=1; the timer starts at 0 on entry.
  - ack=1 restarts the timer at 0.
  - On the edge where timer=SILENCE_CYCLES-1 (so exactly SILENCE_CYCLES cycles in state, absent ack):
    - alarm_in=1 → ALARM re-sound. Blink restarts with siren=1. event_count is NOT incremented.
    - alarm_in=0 → HOLDOFF.
- HOLDOFF:
  - siren=0, lamp=0; alarm_in and ack are ignored.
  - After exactly HOLDOFF_CYCLES cycles → IDLE.
- ack in IDLE, QUALIFY or HOLDOFF is ignored.
- Width rules:
  - Timers are CNT_W bits wide and never wrap within a state.
  - Parameters must be ≤2^CNT_W-1.
  - event_count saturates; it never wraps to 0.

Test Plan:
1. Reset mid-ALARM (siren=1, event_count=1); assert rst for 1 cycle → next edge: state_o=0, siren=0, lamp=0, event_count=0.
2. arm=1; alarm_in high for 3 cycles, then low → states 1,1,1 then 0; siren never 1; event_count stays 0.
3. arm=1; alarm_in high continuously from edge 0:
   - state_o=2 after edge 3, event_count=1.
   - siren high edges 3–10, low 11–18, high from 19.
   - Dropping alarm_in at edge 6 changes nothing.
4. In ALARM, 1-cycle ack pulse with alarm_in=0 → SILENCED (siren=0, lamp=1) for 32 cycles → HOLDOFF (lamp=0) for 16 cycles, alarm_in pulses ignored → IDLE.
5. Repeat scenario 4 with alarm_in=1 throughout:
   - After 32 cycles → ALARM, siren=1, event_count still 1.
   - An ack at SILENCED cycle 20 delays re-sound to 32 cycles after that ack.
6. Saturation and disarm:
   - With CNT_W=2, drive 4 qualified alarms (ack, then let HOLDOFF expire between them) → event_count=3 and holds.
   - arm=0 during ALARM → IDLE next edge with siren=0, count retained.
